// File: rtl/rgb_yuv_pkg.sv
// Shared constants and helpers for the RGB-to-YUV422 conversion pipeline.
// Coefficients are 8-bit fixed-point fractions, stored as signed 9-bit values.
package rgb_yuv_pkg;

  typedef enum logic {
    RANGE_FULL    = 1'b0,
    RANGE_LIMITED = 1'b1
  } range_e;

  localparam int PIPE_LATENCY = 3;

  localparam logic signed [8:0] FULL_Y_R  =  9'sd77;
  localparam logic signed [8:0] FULL_Y_G  =  9'sd150;
  localparam logic signed [8:0] FULL_Y_B  =  9'sd29;
  localparam logic signed [8:0] FULL_U_R  = -9'sd43;
  localparam logic signed [8:0] FULL_U_G  = -9'sd84;
  localparam logic signed [8:0] FULL_U_B  =  9'sd127;
  localparam logic signed [8:0] FULL_V_R  =  9'sd127;
  localparam logic signed [8:0] FULL_V_G  = -9'sd106;
  localparam logic signed [8:0] FULL_V_B  = -9'sd21;
  localparam logic signed [8:0] FULL_Y_OFF  = 9'sd0;
  localparam logic signed [8:0] FULL_UV_OFF = 9'sd128;

  localparam logic signed [8:0] LIM_Y_R   =  9'sd66;
  localparam logic signed [8:0] LIM_Y_G   =  9'sd129;
  localparam logic signed [8:0] LIM_Y_B   =  9'sd25;
  localparam logic signed [8:0] LIM_U_R   = -9'sd38;
  localparam logic signed [8:0] LIM_U_G   = -9'sd74;
  localparam logic signed [8:0] LIM_U_B   =  9'sd112;
  localparam logic signed [8:0] LIM_V_R   =  9'sd112;
  localparam logic signed [8:0] LIM_V_G   = -9'sd94;
  localparam logic signed [8:0] LIM_V_B   = -9'sd18;
  localparam logic signed [8:0] LIM_Y_OFF   = 9'sd16;
  localparam logic signed [8:0] LIM_UV_OFF  = 9'sd128;

  function automatic logic [7:0] clamp_u8(input logic signed [31:0] val);
    logic [7:0] res;
    if (val < 32'sd0) begin
      res = 8'd0;
    end else if (val > 32'sd255) begin
      res = 8'd255;
    end else begin
      res = val[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_yuv_pixel.sv
// One-pixel colour matrix: S1 registers the nine products, S2 sums, rounds,
// shifts, offsets and clamps each of Y, U, V to 8 bits.
module rgb_yuv_pixel
  import rgb_yuv_pkg::*;
#(
  parameter int PIXEL_DEPTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_DEPTH-1:0] red,
  input  logic [PIXEL_DEPTH-1:0] green,
  input  logic [PIXEL_DEPTH-1:0] blue,
  input  range_e                 range_sel,
  output logic [7:0]             y,
  output logic [7:0]             u,
  output logic [7:0]             v
);

  localparam int PROD_W = PIXEL_DEPTH + 10;
  localparam int SUM_W  = PIXEL_DEPTH + 12;
  localparam logic signed [SUM_W-1:0] ROUND_C =
    {{(SUM_W-PIXEL_DEPTH){1'b0}}, 1'b1, {(PIXEL_DEPTH-1){1'b0}}};

  logic signed [8:0]        coef_s [9];
  logic signed [8:0]        off_s  [3];
  logic signed [PROD_W-1:0] pix_s  [3];
  logic signed [PROD_W-1:0] prod_s [9];
  logic signed [PROD_W-1:0] prod_r [9];
  range_e                   range_r;
  logic signed [SUM_W-1:0]  sum_s  [3];
  logic signed [SUM_W-1:0]  res_s  [3];
  logic [7:0]               chan_s [3];
  logic [7:0]               y_r, u_r, v_r;

  // Coefficient matrix for the range this beat travels with; rows Y, U, V.
  always_comb begin
    case (range_sel)
      RANGE_LIMITED: coef_s = '{LIM_Y_R, LIM_Y_G, LIM_Y_B, LIM_U_R, LIM_U_G,
                                LIM_U_B, LIM_V_R, LIM_V_G, LIM_V_B};
      default:       coef_s = '{FULL_Y_R, FULL_Y_G, FULL_Y_B, FULL_U_R, FULL_U_G,
                                FULL_U_B, FULL_V_R, FULL_V_G, FULL_V_B};
    endcase
  end

  // Products of zero-extended colours with the signed coefficients.
  always_comb begin
    pix_s[0] = PROD_W'(red);
    pix_s[1] = PROD_W'(green);
    pix_s[2] = PROD_W'(blue);
    for (int k = 0; k < 9; k++) begin
      prod_s[k] = pix_s[k % 3] * PROD_W'(coef_s[k]);
    end
  end

  // S1 product register; the range follows the products so S2 picks offsets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) prod_r[k] <= '0;
      range_r <= RANGE_FULL;
    end else begin
      prod_r  <= prod_s;
      range_r <= range_sel;
    end
  end

  // Output offsets for the range of the beat now in S2.
  always_comb begin
    case (range_r)
      RANGE_LIMITED: off_s = '{LIM_Y_OFF, LIM_UV_OFF, LIM_UV_OFF};
      default:       off_s = '{FULL_Y_OFF, FULL_UV_OFF, FULL_UV_OFF};
    endcase
  end

  // Sum, round to nearest, floor-shift, offset and saturate each channel.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      sum_s[ch]  = SUM_W'(prod_r[3*ch]) + SUM_W'(prod_r[3*ch+1]) +
                   SUM_W'(prod_r[3*ch+2]) + ROUND_C;
      res_s[ch]  = (sum_s[ch] >>> PIXEL_DEPTH) + SUM_W'(off_s[ch]);
      chan_s[ch] = clamp_u8(32'(res_s[ch]));
    end
  end

  // S2 result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r <= 8'd0;
      u_r <= 8'd0;
      v_r <= 8'd0;
    end else begin
      y_r <= chan_s[0];
      u_r <= chan_s[1];
      v_r <= chan_s[2];
    end
  end

  assign y = y_r;
  assign u = u_r;
  assign v = v_r;

endmodule

// File: rtl/rgb_to_yuv_pipe.sv
// Pipelined RGB-to-YUV422 converter: per-frame mode latch, per-pixel matrix
// stages, then chroma pairing and packing with sideband kept cycle-aligned.
module rgb_to_yuv_pipe
  import rgb_yuv_pkg::*;
#(
  parameter int PIXEL_DEPTH   = 10,
  parameter int LANE_WIDTH    = 16,
  parameter int PIXEL_PER_CLK = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [PIXEL_PER_CLK*3*LANE_WIDTH-1:0] rgb_i,
  input  logic                                rgb_valid_i,
  input  logic                                frame_start_i,
  input  logic                                line_start_i,
  input  logic                                range_sel_i,
  input  logic                                chroma_avg_i,
  output logic [PIXEL_PER_CLK*16-1:0]         yuv_o,
  output logic                                yuv_valid_o,
  output logic                                frame_start_o,
  output logic                                line_start_o
);

  localparam int PAIRS = PIXEL_PER_CLK / 2;

  if ((PIXEL_PER_CLK % 2) != 0) begin : g_odd_ppc
    $error("PIXEL_PER_CLK must be even");
  end

  range_e     range_q_r, range_cur_s;
  logic       avg_q_r, avg_cur_s;
  logic [1:0] vld_p_r, fs_p_r, ls_p_r, avg_p_r;
  logic [7:0] y_s [PIXEL_PER_CLK];
  logic [7:0] u_s [PIXEL_PER_CLK];
  logic [7:0] v_s [PIXEL_PER_CLK];
  logic [8:0] u_sum_s, v_sum_s;
  logic [7:0] u_pair_s, v_pair_s;
  logic [PIXEL_PER_CLK*16-1:0] yuv_nxt_s;
  logic       unused_lane_bits_s;

  assign unused_lane_bits_s = ^rgb_i;

  // A frame-start beat applies its own mode; otherwise the latched mode holds.
  always_comb begin
    if (rgb_valid_i && frame_start_i) begin
      range_cur_s = range_e'(range_sel_i);
      avg_cur_s   = chroma_avg_i;
    end else begin
      range_cur_s = range_q_r;
      avg_cur_s   = avg_q_r;
    end
  end

  // Per-frame mode latch.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      range_q_r <= RANGE_FULL;
      avg_q_r   <= 1'b0;
    end else begin
      range_q_r <= range_cur_s;
      avg_q_r   <= avg_cur_s;
    end
  end

  // Valid, sideband and chroma mode ride alongside S1 and S2.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_p_r <= 2'b00;
      fs_p_r  <= 2'b00;
      ls_p_r  <= 2'b00;
      avg_p_r <= 2'b00;
    end else begin
      vld_p_r <= {vld_p_r[0], rgb_valid_i};
      fs_p_r  <= {fs_p_r[0], rgb_valid_i & frame_start_i};
      ls_p_r  <= {ls_p_r[0], rgb_valid_i & line_start_i};
      avg_p_r <= {avg_p_r[0], avg_cur_s};
    end
  end

  for (genvar p = 0; p < PIXEL_PER_CLK; p++) begin : g_pix
    localparam int BASE = (PIXEL_PER_CLK - 1 - p) * 3 * LANE_WIDTH;
    rgb_yuv_pixel #(
      .PIXEL_DEPTH(PIXEL_DEPTH)
    ) u_pixel (
      .clk       (clk_i),
      .rst_n     (reset_i),
      .red       (rgb_i[BASE + 2*LANE_WIDTH +: PIXEL_DEPTH]),
      .green     (rgb_i[BASE + LANE_WIDTH +: PIXEL_DEPTH]),
      .blue      (rgb_i[BASE +: PIXEL_DEPTH]),
      .range_sel (range_cur_s),
      .y         (y_s[p]),
      .u         (u_s[p]),
      .v         (v_s[p])
    );
  end

  // Pair chroma inside the beat and pack {Y even, U, Y odd, V}, pair 0 on top.
  always_comb begin
    yuv_nxt_s = '0;
    u_sum_s   = 9'd0;
    v_sum_s   = 9'd0;
    u_pair_s  = 8'd0;
    v_pair_s  = 8'd0;
    for (int k = 0; k < PAIRS; k++) begin
      u_sum_s = {1'b0, u_s[2*k]} + {1'b0, u_s[2*k+1]} + 9'd1;
      v_sum_s = {1'b0, v_s[2*k]} + {1'b0, v_s[2*k+1]} + 9'd1;
      if (avg_p_r[1]) begin
        u_pair_s = u_sum_s[8:1];
        v_pair_s = v_sum_s[8:1];
      end else begin
        u_pair_s = u_s[2*k];
        v_pair_s = v_s[2*k];
      end
      yuv_nxt_s[(PAIRS-1-k)*32 +: 32] = {y_s[2*k], u_pair_s, y_s[2*k+1], v_pair_s};
    end
  end

  // S3 output register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      yuv_o         <= '0;
      yuv_valid_o   <= 1'b0;
      frame_start_o <= 1'b0;
      line_start_o  <= 1'b0;
    end else begin
      yuv_o         <= yuv_nxt_s;
      yuv_valid_o   <= vld_p_r[1];
      frame_start_o <= fs_p_r[1];
      line_start_o  <= ls_p_r[1];
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_pipe.sv
// Self-checking bench for rgb_to_yuv_pipe: directed cases from hand-derived
// values plus randomized beats against an integer-arithmetic reference model.
module tb_rgb_to_yuv_pipe;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [191:0] rgb;
  logic         valid, fs, ls, rsel, cavg;
  logic [63:0]  yuv;
  logic         yv, fso, lso;
  int           errors = 0;
  int           checks = 0;
  bit           m_range, m_avg;

  int coef_full[9] = '{77, 150, 29, -43, -84, 127, 127, -106, -21};
  int coef_lim[9]  = '{66, 129, 25, -38, -74, 112, 112, -94, -18};
  int off_full[3]  = '{0, 128, 128};
  int off_lim[3]   = '{16, 128, 128};

  localparam logic [191:0] WHITE = {12{16'h03FF}};
  localparam logic [191:0] BLACK = 192'h0;
  localparam logic [191:0] RED0  = {16'h03FF, 16'h0000, 16'h0000, 144'h0};

  always #5 clk = ~clk;

  rgb_to_yuv_pipe #(
    .PIXEL_DEPTH(10), .LANE_WIDTH(16), .PIXEL_PER_CLK(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .rgb_i(rgb), .rgb_valid_i(valid),
    .frame_start_i(fs), .line_start_i(ls), .range_sel_i(rsel), .chroma_avg_i(cavg),
    .yuv_o(yuv), .yuv_valid_o(yv), .frame_start_o(fso), .line_start_o(lso)
  );

  function automatic int sat8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Reference: plain integer matrix per pixel, then 4:2:2 pairing.
  function automatic logic [63:0] model_beat(input logic [191:0] d, input bit lim, input bit avg);
    int px[3];
    int yy[4], uu[4], vv[4];
    int acc, ch_val[3], up, vp;
    logic [63:0] out;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) px[c] = int'(d[(3-p)*48 + (2-c)*16 +: 10]);
      for (int ch = 0; ch < 3; ch++) begin
        acc = 0;
        for (int c = 0; c < 3; c++) acc += (lim ? coef_lim[3*ch+c] : coef_full[3*ch+c]) * px[c];
        ch_val[ch] = sat8(((acc + 512) >>> 10) + (lim ? off_lim[ch] : off_full[ch]));
      end
      yy[p] = ch_val[0]; uu[p] = ch_val[1]; vv[p] = ch_val[2];
    end
    out = 64'h0;
    for (int k = 0; k < 2; k++) begin
      up = avg ? (uu[2*k] + uu[2*k+1] + 1) / 2 : uu[2*k];
      vp = avg ? (vv[2*k] + vv[2*k+1] + 1) / 2 : vv[2*k];
      out[(1-k)*32 +: 32] = {8'(yy[2*k]), 8'(up), 8'(yy[2*k+1]), 8'(vp)};
    end
    return out;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [191:0] d, input logic v, input logic f, input logic l,
                       input logic r, input logic a);
    rgb = d; valid = v; fs = f; ls = l; rsel = r; cavg = a;
    if (v && f) begin m_range = r; m_avg = a; end
  endtask

  task automatic idle();
    drive(BLACK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle(); m_range = 1'b0; m_avg = 1'b0;
    repeat (2) tick();
    checks++; if (yuv !== 64'h0) begin errors++; $display("FAIL reset_yuv actual=%h required=%h", yuv, 64'h0); end
    checks++; if (yv !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", yv); end
    checks++; if (fso !== 1'b0) begin errors++; $display("FAIL reset_fs actual=%b required=0", fso); end
    checks++; if (lso !== 1'b0) begin errors++; $display("FAIL reset_ls actual=%b required=0", lso); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_white();
    drive(WHITE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle(); tick();
    checks++; if (yv !== 1'b0) begin errors++; $display("FAIL white_early_valid actual=%b required=0", yv); end
    tick();
    checks++; if (yuv !== 64'hFF80FF80_FF80FF80) begin errors++; $display("FAIL white_full actual=%h required=%h", yuv, 64'hFF80FF80_FF80FF80); end
    checks++; if (yv !== 1'b1) begin errors++; $display("FAIL white_valid actual=%b required=1", yv); end
    checks++; if (fso !== 1'b1) begin errors++; $display("FAIL white_fs actual=%b required=1", fso); end
    checks++; if (lso !== 1'b0) begin errors++; $display("FAIL white_ls actual=%b required=0", lso); end
    tick();
    checks++; if (yv !== 1'b0 || fso !== 1'b0) begin errors++; $display("FAIL white_after actual=%b%b required=00", yv, fso); end
  endtask

  task automatic test_chroma();
    drive(RED0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(RED0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    idle(); tick();
    checks++; if (yuv !== 64'h4D5500FF_00800080) begin errors++; $display("FAIL chroma_even actual=%h required=%h", yuv, 64'h4D5500FF_00800080); end
    tick();
    checks++; if (yuv !== 64'h4D6B00C0_00800080) begin errors++; $display("FAIL chroma_avg actual=%h required=%h", yuv, 64'h4D6B00C0_00800080); end
    tick();
  endtask

  task automatic test_limited();
    drive(WHITE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(BLACK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(RED0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    checks++; if (yuv !== 64'hEC80EC80_EC80EC80) begin errors++; $display("FAIL lim_white actual=%h required=%h", yuv, 64'hEC80EC80_EC80EC80); end
    idle(); tick();
    checks++; if (yuv !== 64'h10801080_10801080) begin errors++; $display("FAIL lim_black actual=%h required=%h", yuv, 64'h10801080_10801080); end
    tick();
    checks++; if (yuv[63:56] !== 8'd82) begin errors++; $display("FAIL lim_red_y actual=%0d required=82", yuv[63:56]); end
    checks++; if (yuv !== 64'h525A10F0_10801080) begin errors++; $display("FAIL lim_red actual=%h required=%h", yuv, 64'h525A10F0_10801080); end
  endtask

  task automatic test_mode_latch();
    drive(WHITE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(WHITE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(WHITE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    checks++; if (yuv !== 64'hEC80EC80_EC80EC80) begin errors++; $display("FAIL latch_hold actual=%h required=%h", yuv, 64'hEC80EC80_EC80EC80); end
    idle(); tick();
    checks++; if (yuv !== 64'hFF80FF80_FF80FF80) begin errors++; $display("FAIL latch_new actual=%h required=%h", yuv, 64'hFF80FF80_FF80FF80); end
    tick();
    checks++; if (yuv !== 64'hFF80FF80_FF80FF80) begin errors++; $display("FAIL latch_after actual=%h required=%h", yuv, 64'hFF80FF80_FF80FF80); end
  endtask

  task automatic test_valid_pattern();
    bit vp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit lp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0]  ed[4];
    logic [191:0] d;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        // the bubble carries frame_start with a range change that must be ignored
        drive(d, vp[t], 1'(t == 1), lp[t], 1'(t == 1), 1'(t == 1));
        ed[t] = model_beat(d, m_range, m_avg);
      end else begin
        idle();
      end
      tick();
      if (t >= 2) begin
        checks++; if (yv !== vp[t-2]) begin errors++; $display("FAIL vpat_valid beat=%0d actual=%b required=%b", t-2, yv, vp[t-2]); end
        checks++; if (lso !== lp[t-2]) begin errors++; $display("FAIL vpat_ls beat=%0d actual=%b required=%b", t-2, lso, lp[t-2]); end
        checks++; if (fso !== 1'b0) begin errors++; $display("FAIL vpat_fs beat=%0d actual=%b required=0", t-2, fso); end
        if (vp[t-2]) begin
          checks++; if (yuv !== ed[t-2]) begin errors++; $display("FAIL vpat_data beat=%0d actual=%h required=%h", t-2, yuv, ed[t-2]); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]  ed[$];
    bit           ev[$], ef[$], el[$];
    logic [191:0] d;
    logic         v, f, l;
    for (int t = 0; t < 202; t++) begin
      if (t < 200) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        v = ($urandom_range(3, 0) != 0);
        f = ($urandom_range(7, 0) == 0);
        l = ($urandom_range(3, 0) == 0);
        drive(d, v, f, l, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        ed.push_back(model_beat(d, m_range, m_avg));
        ev.push_back(v); ef.push_back(v && f); el.push_back(v && l);
      end else begin
        idle();
      end
      tick();
      if (t >= 2) begin
        checks++; if (yv !== ev[t-2]) begin errors++; $display("FAIL rand_valid beat=%0d actual=%b required=%b", t-2, yv, ev[t-2]); end
        checks++; if (fso !== ef[t-2] || lso !== el[t-2]) begin errors++; $display("FAIL rand_side beat=%0d actual=%b%b required=%b%b", t-2, fso, lso, ef[t-2], el[t-2]); end
        if (ev[t-2]) begin
          checks++; if (yuv !== ed[t-2]) begin errors++; $display("FAIL rand_data beat=%0d actual=%h required=%h", t-2, yuv, ed[t-2]); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(WHITE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    drive(WHITE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick(); tick();
    checks++; if (yv !== 1'b1) begin errors++; $display("FAIL arst_pre_valid actual=%b required=1", yv); end
    #2 reset_n = 1'b0;
    idle(); m_range = 1'b0; m_avg = 1'b0;
    #1;
    checks++; if (yuv !== 64'h0) begin errors++; $display("FAIL arst_yuv actual=%h required=%h", yuv, 64'h0); end
    checks++; if (yv !== 1'b0 || fso !== 1'b0 || lso !== 1'b0) begin errors++; $display("FAIL arst_flags actual=%b%b%b required=000", yv, fso, lso); end
    tick();
    #2 reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if (yv !== 1'b0) begin errors++; $display("FAIL arst_idle cycle=%0d actual=%b required=0", t, yv); end
    end
    drive(WHITE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    idle(); tick();
    checks++; if (yv !== 1'b0) begin errors++; $display("FAIL arst_early actual=%b required=0", yv); end
    tick();
    checks++; if (yv !== 1'b1) begin errors++; $display("FAIL arst_first_valid actual=%b required=1", yv); end
    checks++; if (yuv !== 64'hFF80FF80_FF80FF80) begin errors++; $display("FAIL arst_mode_cleared actual=%h required=%h", yuv, 64'hFF80FF80_FF80FF80); end
  endtask

  initial begin
    test_reset();
    test_full_white();
    test_chroma();
    test_limited();
    test_mode_latch();
    test_valid_pattern();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
